fir_param: RTL and testbench

Parametrised FIR engine, the successor to the fixed 11-tap `fir`. Taps and configuration are loaded over AXI4-Lite; samples stream in on AXI4-Stream slave and results stream out on AXI4-Stream master. The tap count is set at run time (1..`Tape_Num`), and run length is programmable. Coefficients and sample history live in the external tap and data BRAMs, computed one multiply-accumulate (MAC) per cycle.

---
 rtl/fir_param.sv | 238 +++++++++++++++++++++++
 tb/tb_fir_param.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_param.sv
// Run-time configurable FIR engine: AXI-Lite configuration, AXI-Stream samples in/results out,
// one MAC per cycle against external tap and data BRAMs (1-cycle read latency).
module fir_param #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic                   rvalid,
  input  logic                   rready,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tvalid,
  output logic                   ss_tready,
  input  logic                   ss_tlast,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic                   sm_tlast,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic [3:0]             data_WE,
  output logic                   data_EN,
  output logic [pDATA_WIDTH-1:0] data_Di,
  output logic [pADDR_WIDTH-1:0] data_A,
  input  logic [pDATA_WIDTH-1:0] data_Do
);
  localparam int IW = $clog2(Tape_Num + 1);
  localparam logic [pADDR_WIDTH-1:0] A_CTRL    = pADDR_WIDTH'(32'h00);
  localparam logic [pADDR_WIDTH-1:0] A_LEN     = pADDR_WIDTH'(32'h10);
  localparam logic [pADDR_WIDTH-1:0] A_NTAP    = pADDR_WIDTH'(32'h14);
  localparam logic [pADDR_WIDTH-1:0] A_TAP     = pADDR_WIDTH'(32'h40);
  localparam logic [pADDR_WIDTH-1:0] A_TAP_END = pADDR_WIDTH'(32'h40 + 4 * Tape_Num);
  localparam logic [IW-1:0]          LAST_IDX  = IW'(Tape_Num - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WAIT, S_MAC, S_OUT} state_t;

  state_t                         r_state, w_state_nx;
  logic                           r_start, r_done;
  logic [pDATA_WIDTH-1:0]         r_len, r_cnt;
  logic [IW-1:0]                  r_ntap, r_ptr, r_didx, r_k;
  logic signed [pDATA_WIDTH-1:0]  r_acc;
  logic                           r_vld_p1;
  logic                           r_awready, r_arready, r_rvalid, r_rd_ctrl;
  logic                           r_rd_p0, r_rd_tap_p0, r_rd_ctrl_p0;
  logic [pDATA_WIDTH-1:0]         r_rd_val_p0, r_rdata, w_rd_mux;
  logic w_idle, w_wr, w_rd, w_aw_tap, w_ar_tap, w_wr_tap, w_rd_tap, w_mac_rd, w_last;
  logic w_unused;

  // Products keep only their low pDATA_WIDTH bits; the sum wraps.
  function automatic logic signed [pDATA_WIDTH-1:0] mac_trunc(
    input logic signed [pDATA_WIDTH-1:0] acc,
    input logic signed [pDATA_WIDTH-1:0] a,
    input logic signed [pDATA_WIDTH-1:0] b);
    logic signed [pDATA_WIDTH-1:0] p;
    p = a * b;
    return acc + p;
  endfunction

  assign w_unused = ss_tlast;
  assign w_idle   = (r_state == S_IDLE);
  assign w_wr     = r_awready & awvalid & wvalid;
  assign w_rd     = r_arready & arvalid;
  assign w_aw_tap = (awaddr >= A_TAP) && (awaddr < A_TAP_END);
  assign w_ar_tap = (araddr >= A_TAP) && (araddr < A_TAP_END);
  assign w_wr_tap = w_wr & w_aw_tap & w_idle;
  assign w_rd_tap = w_rd & w_ar_tap & w_idle;
  assign w_mac_rd = (r_state == S_MAC) && (r_k < r_ntap);
  assign w_last   = ((r_cnt + 32'd1) == r_len);

  assign awready   = r_awready;
  assign wready    = r_awready;
  assign arready   = r_arready;
  assign rvalid    = r_rvalid;
  assign rdata     = r_rdata;
  assign ss_tready = (r_state == S_WAIT);
  assign sm_tvalid = (r_state == S_OUT);
  assign sm_tlast  = (r_state == S_OUT) && w_last;
  assign sm_tdata  = r_acc;

  always_comb begin
    w_rd_mux = '0;
    if (w_ar_tap) w_rd_mux = '1;
    else if (araddr == A_CTRL) w_rd_mux = pDATA_WIDTH'({w_idle, r_done, r_start});
    else if (araddr == A_LEN)  w_rd_mux = r_len;
    else if (araddr == A_NTAP) w_rd_mux = pDATA_WIDTH'(r_ntap);
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (r_start) w_state_nx = S_CLEAR;
      S_CLEAR: if (r_k == LAST_IDX) w_state_nx = (r_len == '0) ? S_IDLE : S_WAIT;
      S_WAIT:  if (ss_tvalid) w_state_nx = S_MAC;
      S_MAC:   if (r_k == r_ntap) w_state_nx = S_OUT;
      S_OUT:   if (sm_tready) w_state_nx = w_last ? S_IDLE : S_WAIT;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // AXI-Lite owns the tap port in IDLE, the engine everywhere else.
  always_comb begin
    tap_EN = 1'b0;
    tap_WE = 4'h0;
    tap_A  = '0;
    tap_Di = '0;
    if (w_idle) begin
      if (w_wr_tap) begin
        tap_EN = 1'b1;
        tap_WE = 4'hF;
        tap_A  = awaddr - A_TAP;
        tap_Di = wdata;
      end else if (w_rd_tap) begin
        tap_EN = 1'b1;
        tap_A  = araddr - A_TAP;
      end
    end else if (w_mac_rd) begin
      tap_EN = 1'b1;
      tap_A  = pADDR_WIDTH'(r_k) << 2;
    end
  end

  always_comb begin
    data_EN = 1'b0;
    data_WE = 4'h0;
    data_A  = '0;
    data_Di = '0;
    case (r_state)
      S_CLEAR: begin
        data_EN = 1'b1;
        data_WE = 4'hF;
        data_A  = pADDR_WIDTH'(r_k) << 2;
      end
      S_WAIT: if (ss_tvalid) begin
        data_EN = 1'b1;
        data_WE = 4'hF;
        data_A  = pADDR_WIDTH'(r_ptr) << 2;
        data_Di = ss_tdata;
      end
      S_MAC: if (w_mac_rd) begin
        data_EN = 1'b1;
        data_A  = pADDR_WIDTH'(r_didx) << 2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_state <= S_IDLE;    r_start <= 1'b0;   r_done <= 1'b0;
      r_len <= '0;          r_ntap <= IW'(Tape_Num);
      r_cnt <= '0;          r_ptr <= '0;       r_didx <= '0;     r_k <= '0;
      r_acc <= '0;          r_vld_p1 <= 1'b0;
      r_awready <= 1'b0;    r_arready <= 1'b0; r_rvalid <= 1'b0; r_rdata <= '0;
      r_rd_ctrl <= 1'b0;    r_rd_p0 <= 1'b0;   r_rd_tap_p0 <= 1'b0;
      r_rd_ctrl_p0 <= 1'b0; r_rd_val_p0 <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_awready <= awvalid & wvalid & ~r_awready;
      // Hold off reads that would collide with a tap write on the shared port.
      r_arready <= arvalid & ~r_arready & ~r_rd_p0 & ~r_rvalid & ~(awvalid & wvalid & w_aw_tap);

      if (w_wr && w_idle) begin
        if (awaddr == A_CTRL && wdata[0]) r_start <= 1'b1;
        if (awaddr == A_LEN) r_len <= wdata;
        if (awaddr == A_NTAP)
          r_ntap <= (wdata == '0 || wdata > pDATA_WIDTH'(Tape_Num)) ? IW'(Tape_Num) : wdata[IW-1:0];
      end

      // Read stage p0: address accepted, register value snapshotted before any same-cycle write.
      r_rd_p0 <= w_rd;
      if (w_rd) begin
        r_rd_val_p0  <= w_rd_mux;
        r_rd_tap_p0  <= w_rd_tap;
        r_rd_ctrl_p0 <= (araddr == A_CTRL);
      end
      // Read stage p1: tap BRAM data has arrived; present and hold until rready.
      if (r_rd_p0) begin
        r_rvalid  <= 1'b1;
        r_rdata   <= r_rd_tap_p0 ? tap_Do : r_rd_val_p0;
        r_rd_ctrl <= r_rd_ctrl_p0;
      end else if (r_rvalid && rready) begin
        r_rvalid <= 1'b0;
        if (r_rd_ctrl) r_done <= 1'b0;
      end

      case (r_state)
        S_IDLE: if (r_start) begin
          r_start <= 1'b0;
          r_done  <= 1'b0;
          r_k     <= '0;
          r_ptr   <= '0;
          r_cnt   <= '0;
        end
        S_CLEAR: begin
          r_k <= r_k + 1'b1;
          if (r_k == LAST_IDX) begin
            r_k <= '0;
            if (r_len == '0) r_done <= 1'b1;
          end
        end
        S_WAIT: if (ss_tvalid) begin
          r_didx   <= r_ptr;
          r_k      <= '0;
          r_acc    <= '0;
          r_vld_p1 <= 1'b0;
        end
        S_MAC: begin
          r_vld_p1 <= w_mac_rd;
          if (w_mac_rd) begin
            r_k    <= r_k + 1'b1;
            r_didx <= (r_didx == '0) ? LAST_IDX : r_didx - 1'b1;
          end
          if (r_vld_p1) r_acc <= mac_trunc(r_acc, $signed(tap_Do), $signed(data_Do));
        end
        S_OUT: if (sm_tready) begin
          r_ptr <= (r_ptr == LAST_IDX) ? '0 : r_ptr + 1'b1;
          r_cnt <= r_cnt + 32'd1;
          if (w_last) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_param.sv
// Directed bench for fir_param: BRAM models, AXI-Lite/Stream tasks, vector tables and
// hand-written sequences for backpressure, busy protection, zero length and mid-run reset.
module tb_fir_param;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NT = 11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] awaddr, araddr, tap_A, data_A;
  logic          awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata, ss_tdata, sm_tdata, tap_Di, tap_Do, data_Di, data_Do;
  logic          ss_tvalid, ss_tready, ss_tlast, sm_tvalid, sm_tready, sm_tlast;
  logic [3:0]    tap_WE, data_WE;
  logic          tap_EN, data_EN;

  fir_param #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT)) dut (
    .axis_clk(clk), .axis_rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .ss_tdata(ss_tdata), .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tlast(ss_tlast),
    .sm_tdata(sm_tdata), .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tlast(sm_tlast),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
    .data_WE(data_WE), .data_EN(data_EN), .data_Di(data_Di), .data_A(data_A), .data_Do(data_Do)
  );

  logic [DW-1:0] tap_mem  [0:1023];
  logic [DW-1:0] data_mem [0:1023];
  always @(posedge clk) begin
    if (tap_EN) begin
      if (tap_WE == 4'hF) tap_mem[tap_A[AW-1:2]] <= tap_Di;
      tap_Do <= tap_mem[tap_A[AW-1:2]];
    end
    if (data_EN) begin
      if (data_WE == 4'hF) data_mem[data_A[AW-1:2]] <= data_Di;
      data_Do <= data_mem[data_A[AW-1:2]];
    end
  end

  typedef struct { logic [31:0] x; logic [31:0] y; logic last; } vec_t;

  int n_checks = 0;
  int n_err    = 0;
  int taps [0:NT-1] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
  vec_t imp [0:NT-1];
  vec_t tri3 [0:3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d);
    int i;
    @(negedge clk);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awready && wready) break;
    end
    if (i == 20) timeout_fail("axi_write");
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d);
    int i;
    d = '0;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arready) break;
    end
    if (i == 20) timeout_fail("axi_read_addr");
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rvalid) break;
    end
    if (i == 20) timeout_fail("axi_read_data");
    else d = rdata;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [AW-1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(a, d);
    check(name, d, exp);
  endtask

  task automatic send_in(input logic [31:0] x);
    int i;
    @(negedge clk);
    ss_tdata = x; ss_tvalid = 1'b1;
    for (i = 0; i < 100; i++) begin
      if (ss_tready) break;
      @(negedge clk);
    end
    if (i == 100) timeout_fail("ss_tready");
    @(posedge clk); #1;
    ss_tvalid = 1'b0;
  endtask

  // One sample in, one result out; exp_lat > 0 also checks handshake-to-tvalid cycles.
  task automatic run_sample(input vec_t v, input bit bp, input int exp_lat);
    int lat;
    if (bp) sm_tready = 1'b0;
    send_in(v.x);
    for (lat = 1; lat <= 200; lat++) begin
      @(negedge clk);
      if (sm_tvalid) break;
    end
    if (lat > 200) begin
      timeout_fail("sm_tvalid");
    end else begin
      if (exp_lat > 0) check("latency", lat, exp_lat);
      check("sm_tdata", sm_tdata, v.y);
      check("sm_tlast", {31'b0, sm_tlast}, {31'b0, v.last});
      if (bp) begin
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          check("bp_tdata", sm_tdata, v.y);
          check("bp_tvalid", {31'b0, sm_tvalid}, 32'd1);
          check("bp_ss_tready", {31'b0, ss_tready}, 32'd0);
        end
        sm_tready = 1'b1;
        @(posedge clk); #1;
      end
    end
  endtask

  function automatic logic [31:0] golden(input int n, input int nt);
    int acc;
    acc = 0;
    for (int k = 0; k < nt; k++)
      if (n - k >= 0) acc += taps[k] * (n - k);
    return acc;
  endfunction

  task automatic run_impulse();
    axi_write(12'h014, 32'd11);
    axi_write(12'h010, 32'd11);
    axi_write(12'h000, 32'd1);
    for (int i = 0; i < NT; i++) run_sample(imp[i], 1'b0, (i == 0) ? NT + 2 : 0);
    read_check("ctrl_done", 12'h000, 32'h6);
    read_check("ctrl_reread", 12'h000, 32'h4);
  endtask

  initial begin
    logic [31:0] d;
    for (int i = 0; i < 1024; i++) begin
      tap_mem[i]  = 32'h0;
      data_mem[i] = 32'hDEADBEEF;
    end
    for (int i = 0; i < NT; i++) begin
      imp[i].x = (i == 0) ? 32'd1 : 32'd0;
      imp[i].y = taps[i];
      imp[i].last = (i == NT - 1);
    end
    tri3[0] = '{32'd1, 32'd1, 1'b0};
    tri3[1] = '{32'd1, 32'd3, 1'b0};
    tri3[2] = '{32'd1, 32'd6, 1'b0};
    tri3[3] = '{32'd1, 32'd6, 1'b1};

    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    ss_tdata = '0; ss_tvalid = 1'b0; ss_tlast = 1'b0; sm_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_awready", {31'b0, awready}, 32'd0);
    check("rst_rvalid", {31'b0, rvalid}, 32'd0);
    check("rst_ss_tready", {31'b0, ss_tready}, 32'd0);
    check("rst_sm_tvalid", {31'b0, sm_tvalid}, 32'd0);
    check("rst_sm_tdata", sm_tdata, 32'd0);
    check("rst_bram_en", {30'b0, tap_EN, data_EN}, 32'd0);
    read_check("rst_ctrl", 12'h000, 32'h4);
    read_check("rst_len", 12'h010, 32'd0);
    read_check("rst_ntap", 12'h014, 32'd11);

    axi_write(12'h014, 32'd0);
    read_check("ntap_zero", 12'h014, 32'd11);
    axi_write(12'h014, 32'd20);
    read_check("ntap_big", 12'h014, 32'd11);
    axi_write(12'h014, 32'd3);
    read_check("ntap_3", 12'h014, 32'd3);
    axi_write(12'h020, 32'h1234);
    read_check("unmapped", 12'h020, 32'd0);

    for (int i = 0; i < NT; i++) axi_write(12'h040 + 12'(4 * i), taps[i]);
    read_check("tap3_rb", 12'h04C, 32'd23);
    read_check("tap9_rb", 12'h064, 32'hFFFFFFF6);

    run_impulse();

    for (int i = 0; i < 3; i++) axi_write(12'h040 + 12'(4 * i), i + 1);
    axi_write(12'h014, 32'd3);
    axi_write(12'h010, 32'd4);
    axi_write(12'h000, 32'd1);
    ss_tlast = 1'b1;
    for (int i = 0; i < 4; i++) run_sample(tri3[i], 1'b1, (i == 0) ? 5 : 0);
    ss_tlast = 1'b0;
    read_check("tri_ctrl", 12'h000, 32'h6);

    for (int i = 0; i < 3; i++) axi_write(12'h040 + 12'(4 * i), taps[i]);
    axi_write(12'h014, 32'd11);
    axi_write(12'h010, 32'd64);
    axi_write(12'h000, 32'd1);
    for (int n = 0; n < 64; n++) begin
      vec_t v;
      v.x = n; v.y = golden(n, NT); v.last = (n == 63);
      if (n == 20) begin
        axi_write(12'h040, 32'd99);
        read_check("busy_tap", 12'h040, 32'hFFFFFFFF);
        axi_write(12'h010, 32'd5);
        read_check("busy_len", 12'h010, 32'd64);
        axi_write(12'h000, 32'd1);
        read_check("busy_ctrl", 12'h000, 32'h0);
      end
      run_sample(v, 1'b0, (n == 0) ? NT + 2 : 0);
    end
    read_check("ramp_ctrl", 12'h000, 32'h6);
    read_check("tap0_kept", 12'h040, 32'd0);

    axi_write(12'h010, 32'd0);
    axi_write(12'h000, 32'd1);
    repeat (20) @(negedge clk);
    read_check("len0_ctrl", 12'h000, 32'h6);
    read_check("len0_reread", 12'h000, 32'h4);

    axi_write(12'h010, 32'd64);
    fork
      axi_write(12'h000, 32'd1);
      begin
        logic [31:0] rd;
        axi_read(12'h000, rd);
        check("simul_ctrl", rd, 32'h4);
      end
    join
    send_in(32'd5);
    repeat (3) @(negedge clk);
    check("mid_mac_tvalid", {31'b0, sm_tvalid}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tvalid", {31'b0, sm_tvalid}, 32'd0);
    check("post_rst_ss_tready", {31'b0, ss_tready}, 32'd0);
    read_check("post_rst_ctrl", 12'h000, 32'h4);
    read_check("post_rst_len", 12'h010, 32'd0);
    axi_read(12'h044, d);
    check("post_rst_tap1", d, 32'hFFFFFFF6);

    run_impulse();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, %0d checks so far", n_checks);
    $fatal(1, "timeout");
  end
endmodule
